// File: rtl/nv_nvdla_sdp_cmux_sel_if.sv
// Valid/ready/payload stream used for the SDP cmux source and sink ports.
// Payload layout: [DW-1:0] data, [DW] batch_end, [DW+1] layer_end.
interface nv_nvdla_sdp_cmux_sel_if #(
    parameter int DW = 256
);
    logic          valid;
    logic          ready;
    logic [DW+1:0] pd;

    modport master (output valid, output pd, input ready);
    modport slave  (input valid, input pd, output ready);
endinterface

// File: rtl/nv_nvdla_sdp_cmux_sel.sv
// SDP input selector: per-layer choice of cacc or mrdma stream into a 2-entry skid buffer.
// Optional stall counter guarded by NVDLA_SDP_CMUX_STALL_CNT_EN (absent: stall output tied to 0).
module nv_nvdla_sdp_cmux_sel #(
    parameter int DW = 256
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    reg2dp_op_en,
    input  logic                    reg2dp_flying_mode,
    nv_nvdla_sdp_cmux_sel_if.slave  cacc2sdp,
    nv_nvdla_sdp_cmux_sel_if.slave  sdp_mrdma2cmux,
    nv_nvdla_sdp_cmux_sel_if.master sdp_cmux2dp,
    output logic                    dp2reg_cmux_done,
    output logic [31:0]             dp2reg_cmux_stall
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          wr_ptr_q, rd_ptr_q;
    logic [DW+1:0] mem_q [2];
    logic          done_q, done_d;

    logic          op_load;
    logic          sel_rdy;
    logic          sel_vld;
    logic [DW+1:0] sel_pd;
    logic          push;
    logic          pop;

    assign op_load = reg2dp_op_en & (state_q == ST_IDLE);

    // Readies depend only on registered state/count, never on the sink ready.
    assign sel_rdy              = (state_q == ST_RUN) & (cnt_q != 2'd2);
    assign cacc2sdp.ready       = sel_rdy & sel_q;
    assign sdp_mrdma2cmux.ready = sel_rdy & ~sel_q;

    assign sel_vld = sel_q ? cacc2sdp.valid : sdp_mrdma2cmux.valid;
    assign sel_pd  = sel_q ? cacc2sdp.pd    : sdp_mrdma2cmux.pd;
    assign push    = sel_vld & sel_rdy;

    assign sdp_cmux2dp.valid = (cnt_q != 2'd0);
    assign sdp_cmux2dp.pd    = mem_q[rd_ptr_q];
    assign pop               = sdp_cmux2dp.valid & sdp_cmux2dp.ready;

    assign dp2reg_cmux_done = done_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_load) begin
                    state_d = ST_RUN;
                    sel_d   = reg2dp_flying_mode;
                end
            end
            ST_RUN: begin
                if (push && sel_pd[DW+1]) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // No pushes in DRAIN, so the last pop is the layer_end beat.
                if (pop && (cnt_q == 2'd1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (push) begin
                mem_q[wr_ptr_q] <= sel_pd;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

`ifdef NVDLA_SDP_CMUX_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (op_load) begin
            stall_d = 32'd0;
        end else if ((state_q != ST_IDLE) && sdp_cmux2dp.valid && !sdp_cmux2dp.ready
                     && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) stall_q <= 32'd0;
        else                  stall_q <= stall_d;
    end

    assign dp2reg_cmux_stall = stall_q;
`else
    assign dp2reg_cmux_stall = 32'd0;
`endif

endmodule
